// File: rtl/bsg_frame_channel_remap_if.sv
// rtl/bsg_frame_channel_remap_if.sv - pad/core link and configuration bundle for the channel remapper
interface bsg_frame_channel_remap_if #(
  parameter int num_channels_p = 4,
  parameter int width_p        = 9
);
  localparam int lg_ch_lp = $clog2(num_channels_p);

  logic [num_channels_p*width_p-1:0]  data_i;
  logic [num_channels_p-1:0]          v_i;
  logic [num_channels_p*width_p-1:0]  data_o;
  logic [num_channels_p-1:0]          v_o;
  logic [num_channels_p-1:0]          token_i;
  logic [num_channels_p-1:0]          token_o;
  logic                               cfg_v_i;
  logic [num_channels_p*lg_ch_lp-1:0] cfg_map_i;
  logic [num_channels_p-1:0]          cfg_en_i;
  logic                               cfg_ready_o;
  logic                               cfg_err_o;
  logic                               busy_o;

  modport master (
    output data_i, v_i, token_i, cfg_v_i, cfg_map_i, cfg_en_i,
    input  data_o, v_o, token_o, cfg_ready_o, cfg_err_o, busy_o
  );

  modport slave (
    input  data_i, v_i, token_i, cfg_v_i, cfg_map_i, cfg_en_i,
    output data_o, v_o, token_o, cfg_ready_o, cfg_err_o, busy_o
  );
endinterface

// File: rtl/bsg_frame_channel_remap.sv
// rtl/bsg_frame_channel_remap.sv - run-time reprogrammable pad/core channel swizzle
// Forward data/valid and reverse tokens go through a map that is only swapped after a drain window.
module bsg_frame_channel_remap #(
  parameter int num_channels_p = 4,
  parameter int width_p        = 9,
  parameter logic [num_channels_p*$clog2(num_channels_p)-1:0] reset_map_p = 'hD8,
  parameter int drain_cycles_p = 4
) (
  input logic                    clk_i,
  input logic                    reset_i,
  bsg_frame_channel_remap_if.slave link
);

  localparam int lg_ch_lp = $clog2(num_channels_p);
  localparam int cnt_w_lp = $clog2(drain_cycles_p + 1);
  localparam logic [cnt_w_lp-1:0] cnt_last_lp = cnt_w_lp'(drain_cycles_p - 1);

  typedef enum logic [1:0] {
    e_idle  = 2'd0,
    e_drain = 2'd1,
    e_apply = 2'd2
  } state_e;

  state_e state_r, state_n;

  logic [lg_ch_lp-1:0]       map_r      [num_channels_p];
  logic [lg_ch_lp-1:0]       pend_map_r [num_channels_p];
  logic [lg_ch_lp-1:0]       cfg_map    [num_channels_p];
  logic [num_channels_p-1:0] en_r, pend_en_r;
  logic [cnt_w_lp-1:0]       cnt_r;

  logic                              cfg_ready, busy, cfg_fire, map_legal;
  logic                              err_r;
  logic [num_channels_p*width_p-1:0] data_r, data_n;
  logic [num_channels_p-1:0]         v_r, v_n, tok_r, tok_n;

  always_comb begin
    for (int i = 0; i < num_channels_p; i++) begin
      cfg_map[i] = link.cfg_map_i[i*lg_ch_lp +: lg_ch_lp];
    end
  end

  // A legal map is a true permutation: in range and no repeated source.
  always_comb begin
    map_legal = 1'b1;
    for (int i = 0; i < num_channels_p; i++) begin
      if (int'(cfg_map[i]) >= num_channels_p) map_legal = 1'b0;
      for (int j = i + 1; j < num_channels_p; j++) begin
        if (cfg_map[i] == cfg_map[j]) map_legal = 1'b0;
      end
    end
  end

  assign cfg_fire = link.cfg_v_i & cfg_ready;

  always_ff @(posedge clk_i) begin
    if (reset_i) state_r <= e_idle;
    else         state_r <= state_n;
  end

  always_comb begin
    state_n = state_r;
    case (state_r)
      e_idle:  if (cfg_fire && map_legal) state_n = e_drain;
      e_drain: if (cnt_r == cnt_last_lp) state_n = e_apply;
      e_apply: state_n = e_idle;
      default: state_n = e_idle;
    endcase
  end

  always_comb begin
    cfg_ready = 1'b0;
    busy      = 1'b0;
    case (state_r)
      e_idle:  cfg_ready = 1'b1;
      e_drain: busy      = 1'b1;
      e_apply: busy      = 1'b1;
      default: busy      = 1'b0;
    endcase
  end

  // Counter saturates at its terminal value; the FSM leaves DRAIN on that same cycle.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_r <= '0;
    end else if (state_r == e_idle) begin
      cnt_r <= '0;
    end else if (state_r == e_drain && cnt_r != cnt_last_lp) begin
      cnt_r <= cnt_r + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < num_channels_p; i++) begin
        map_r[i]      <= reset_map_p[i*lg_ch_lp +: lg_ch_lp];
        pend_map_r[i] <= reset_map_p[i*lg_ch_lp +: lg_ch_lp];
      end
      en_r      <= '1;
      pend_en_r <= '1;
    end else begin
      if (cfg_fire && map_legal) begin
        for (int i = 0; i < num_channels_p; i++) pend_map_r[i] <= cfg_map[i];
        pend_en_r <= link.cfg_en_i;
      end
      if (state_r == e_apply) begin
        for (int i = 0; i < num_channels_p; i++) map_r[i] <= pend_map_r[i];
        en_r <= pend_en_r;
      end
    end
  end

  // Tokens travel the inverse map, so a disabled output starves its source.
  always_comb begin
    data_n = '0;
    v_n    = '0;
    tok_n  = '0;
    for (int i = 0; i < num_channels_p; i++) begin
      data_n[i*width_p +: width_p] = link.data_i[int'(map_r[i])*width_p +: width_p];
      v_n[i]          = link.v_i[map_r[i]] & en_r[i] & (state_r == e_idle);
      tok_n[map_r[i]] = link.token_i[i] & en_r[i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      data_r <= '0;
      v_r    <= '0;
      tok_r  <= '0;
      err_r  <= 1'b0;
    end else begin
      data_r <= data_n;
      v_r    <= v_n;
      tok_r  <= tok_n;
      err_r  <= cfg_fire & ~map_legal;
    end
  end

  assign link.data_o      = data_r;
  assign link.v_o         = v_r;
  assign link.token_o     = tok_r;
  assign link.cfg_err_o   = err_r;
  assign link.cfg_ready_o = cfg_ready;
  assign link.busy_o      = busy;

endmodule

// File: tb/tb_bsg_frame_channel_remap.sv
// tb/tb_bsg_frame_channel_remap.sv - scoreboard and vector bench for the channel remapper
module tb_bsg_frame_channel_remap;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bsg_frame_channel_remap_if #(.num_channels_p(4), .width_p(9))  if4 ();
  bsg_frame_channel_remap_if #(.num_channels_p(3), .width_p(9))  if3 ();
  bsg_frame_channel_remap_if #(.num_channels_p(8), .width_p(16)) if8 ();

  bsg_frame_channel_remap #(.num_channels_p(4), .width_p(9), .reset_map_p(8'hD8),
                            .drain_cycles_p(4)) dut4 (.clk_i(clk), .reset_i(reset), .link(if4));
  bsg_frame_channel_remap #(.num_channels_p(3), .width_p(9), .reset_map_p(6'h18),
                            .drain_cycles_p(2)) dut3 (.clk_i(clk), .reset_i(reset), .link(if3));
  bsg_frame_channel_remap #(.num_channels_p(8), .width_p(16),
                            .reset_map_p({3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd1, 3'd2, 3'd0}),
                            .drain_cycles_p(1)) dut8 (.clk_i(clk), .reset_i(reset), .link(if8));

  typedef struct packed {
    logic [127:0] data;
    logic [7:0]   v;
    logic [7:0]   tok;
    logic         err;
    logic         ready;
    logic         busy;
  } exp_t;

  typedef struct {
    logic [35:0] d;
    logic [3:0]  v;
    logic [3:0]  tok;
    logic [35:0] xd;
    logic [3:0]  xv;
    logic [3:0]  xtok;
  } vec_t;

  int NCH [3] = '{4, 3, 8};
  int WID [3] = '{9, 9, 16};
  int LGC [3] = '{2, 2, 3};
  int DRN [3] = '{4, 2, 1};
  int RMAP[3][8] = '{'{0, 2, 1, 3, 0, 0, 0, 0}, '{0, 2, 1, 0, 0, 0, 0, 0}, '{0, 2, 1, 3, 4, 5, 6, 7}};

  logic [127:0] in_d   [3];
  logic [7:0]   in_v   [3];
  logic [7:0]   in_tok [3];
  logic [7:0]   in_en  [3];
  logic         in_cv  [3];
  logic [23:0]  in_map [3];

  int         mmap [3][8];
  int         pmap [3][8];
  int         mbusy[3];
  logic [7:0] men  [3];
  logic [7:0] pen  [3];

  exp_t sb[3][$];
  exp_t last[3];
  int total = 0;
  int bad = 0;
  int cyc = 0;

  function automatic logic [7:0] chmask(int k);
    return 8'((1 << NCH[k]) - 1);
  endfunction

  function automatic int map_entry(int k, int i);
    int e = 0;
    for (int b = 0; b < LGC[k]; b++) if (in_map[k][i*LGC[k]+b]) e |= (1 << b);
    return e;
  endfunction

  function automatic logic map_ok(int k);
    logic [7:0] seen = '0;
    for (int i = 0; i < NCH[k]; i++) begin
      int e = map_entry(k, i);
      if (e >= NCH[k]) return 1'b0;
      if (seen[e]) return 1'b0;
      seen[e] = 1'b1;
    end
    return 1'b1;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset(input int k);
    for (int i = 0; i < 8; i++) mmap[k][i] = RMAP[k][i];
    men[k]   = chmask(k);
    mbusy[k] = 0;
  endtask

  // Busy countdown model: drain_cycles+1 non-ready cycles, map swapped as it reaches zero.
  task automatic model_step(input int k, output exp_t e);
    int n, w, src;
    logic rdy, ok;
    n = NCH[k];
    w = WID[k];
    e = '0;
    if (reset) begin
      model_reset(k);
      e.ready = 1'b1;
      return;
    end
    rdy = (mbusy[k] == 0);
    for (int i = 0; i < n; i++) begin
      src = mmap[k][i];
      for (int b = 0; b < w; b++) e.data[i*w+b] = in_d[k][src*w+b];
      e.v[i]   = rdy & in_v[k][src] & men[k][i];
      e.tok[src] = in_tok[k][i] & men[k][i];
    end
    ok = map_ok(k);
    e.err = rdy & in_cv[k] & ~ok;
    if (!rdy) begin
      mbusy[k]--;
      if (mbusy[k] == 0) begin
        for (int i = 0; i < 8; i++) mmap[k][i] = pmap[k][i];
        men[k] = pen[k];
      end
    end else if (in_cv[k] && ok) begin
      for (int i = 0; i < n; i++) pmap[k][i] = map_entry(k, i);
      pen[k]   = in_en[k] & chmask(k);
      mbusy[k] = DRN[k] + 1;
    end
    e.ready = (mbusy[k] == 0);
    e.busy  = ~e.ready;
  endtask

  task automatic drive_dut();
    if4.data_i = in_d[0][35:0];  if4.v_i = in_v[0][3:0];  if4.token_i = in_tok[0][3:0];
    if4.cfg_v_i = in_cv[0];      if4.cfg_map_i = in_map[0][7:0];  if4.cfg_en_i = in_en[0][3:0];
    if3.data_i = in_d[1][26:0];  if3.v_i = in_v[1][2:0];  if3.token_i = in_tok[1][2:0];
    if3.cfg_v_i = in_cv[1];      if3.cfg_map_i = in_map[1][5:0];  if3.cfg_en_i = in_en[1][2:0];
    if8.data_i = in_d[2];        if8.v_i = in_v[2];       if8.token_i = in_tok[2];
    if8.cfg_v_i = in_cv[2];      if8.cfg_map_i = in_map[2];       if8.cfg_en_i = in_en[2];
  endtask

  task automatic read_dut(input int k, output exp_t a);
    a = '0;
    case (k)
      0: begin
        a.data[35:0] = if4.data_o; a.v[3:0] = if4.v_o; a.tok[3:0] = if4.token_o;
        a.err = if4.cfg_err_o; a.ready = if4.cfg_ready_o; a.busy = if4.busy_o;
      end
      1: begin
        a.data[26:0] = if3.data_o; a.v[2:0] = if3.v_o; a.tok[2:0] = if3.token_o;
        a.err = if3.cfg_err_o; a.ready = if3.cfg_ready_o; a.busy = if3.busy_o;
      end
      default: begin
        a.data = if8.data_o; a.v = if8.v_o; a.tok = if8.token_o;
        a.err = if8.cfg_err_o; a.ready = if8.cfg_ready_o; a.busy = if8.busy_o;
      end
    endcase
  endtask

  task automatic cycle();
    exp_t e, a;
    for (int k = 0; k < 3; k++) begin
      model_step(k, e);
      sb[k].push_back(e);
    end
    drive_dut();
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < 3; k++) begin
      read_dut(k, a);
      last[k] = a;
      if (sb[k].size() == 0) begin
        total++; bad++;
        $display("FAIL sb_empty k%0d cyc=%0d: got output want queued expectation", k, cyc);
      end else begin
        e = sb[k].pop_front();
        check($sformatf("sb_data k%0d", k),  a.data, e.data);
        check($sformatf("sb_v k%0d", k),     128'(a.v), 128'(e.v));
        check($sformatf("sb_tok k%0d", k),   128'(a.tok), 128'(e.tok));
        check($sformatf("sb_err k%0d", k),   128'(a.err), 128'(e.err));
        check($sformatf("sb_ready k%0d", k), 128'(a.ready), 128'(e.ready));
        check($sformatf("sb_busy k%0d", k),  128'(a.busy), 128'(e.busy));
      end
    end
  endtask

  vec_t tbl[4];
  int   perm[8];
  int   lowc, guard;
  logic pb;

  localparam logic [35:0] A_IN  = {9'hA3, 9'hA2, 9'hA1, 9'hA0};
  localparam logic [35:0] A_DEF = {9'hA3, 9'hA1, 9'hA2, 9'hA0};

  initial begin
    tbl[0] = '{A_IN, 4'b1111, 4'b0010, A_DEF, 4'b1111, 4'b0100};
    tbl[1] = '{{9'h1FF, 9'h000, 9'h155, 9'h0AA}, 4'b0010, 4'b1001,
               {9'h1FF, 9'h155, 9'h000, 9'h0AA}, 4'b0100, 4'b1001};
    tbl[2] = '{{9'h003, 9'h002, 9'h001, 9'h100}, 4'b0101, 4'b0100,
               {9'h003, 9'h001, 9'h002, 9'h100}, 4'b0011, 4'b0010};
    tbl[3] = '{{4{9'h1FF}}, 4'b0000, 4'b1111, {4{9'h1FF}}, 4'b0000, 4'b1111};

    for (int k = 0; k < 3; k++) begin
      in_d[k] = '0; in_v[k] = '0; in_tok[k] = '0; in_cv[k] = 1'b0;
      in_map[k] = '0; in_en[k] = chmask(k);
      model_reset(k);
    end

    reset = 1'b1;
    cycle();
    cycle();
    check("reset_v4", 128'(last[0].v), 128'(0));
    check("reset_ready4", 128'(last[0].ready), 128'(1));
    check("reset_data4", last[0].data, 128'(0));
    reset = 1'b0;

    foreach (tbl[i]) begin
      in_d[0] = 128'(tbl[i].d); in_v[0] = 8'(tbl[i].v); in_tok[0] = 8'(tbl[i].tok);
      cycle();
      check($sformatf("tbl_data %0d", i), last[0].data, 128'(tbl[i].xd));
      check($sformatf("tbl_v %0d", i),    128'(last[0].v), 128'(tbl[i].xv));
      check($sformatf("tbl_tok %0d", i),  128'(last[0].tok), 128'(tbl[i].xtok));
    end

    for (int c = 0; c < 30; c++) begin
      for (int k = 0; k < 3; k++) begin
        in_d[k] = {$urandom, $urandom, $urandom, $urandom};
        in_v[k] = 8'($urandom); in_tok[k] = 8'($urandom);
      end
      cycle();
    end

    in_d[0] = 128'(A_IN); in_v[0] = 8'hF; in_tok[0] = 8'h0;
    in_map[0] = 24'h58; in_en[0] = 8'hF; in_cv[0] = 1'b1;
    cycle();
    in_cv[0] = 1'b0;
    check("illegal_err_pulse", 128'(last[0].err), 128'(1));
    check("illegal_ready", 128'(last[0].ready), 128'(1));
    cycle();
    check("illegal_err_clear", 128'(last[0].err), 128'(0));
    check("illegal_routing", last[0].data, 128'(A_DEF));

    in_map[0] = 24'hE4; in_en[0] = 8'b1011; in_cv[0] = 1'b1;
    cycle();
    in_cv[0] = 1'b0;
    lowc = 0; guard = 0;
    while (last[0].ready == 1'b0 && guard < 20) begin
      lowc++;
      if (lowc > 1) check("drain_v_low", 128'(last[0].v), 128'(0));
      cycle();
      guard++;
    end
    check("reprog_ready_low_cycles", 128'(lowc), 128'(5));
    check("apply_v_low", 128'(last[0].v), 128'(0));
    in_tok[0] = 8'hF;
    cycle();
    check("ident_data", last[0].data, 128'(A_IN));
    check("ident_v_masked", 128'(last[0].v), 128'(4'b1011));
    check("ident_tok_masked", 128'(last[0].tok), 128'(4'b1011));

    in_map[0] = 24'h1B; in_en[0] = 8'b0001; in_cv[0] = 1'b1;
    cycle();
    in_cv[0] = 1'b0;
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("midreset_ready", 128'(last[0].ready), 128'(1));
    check("midreset_busy", 128'(last[0].busy), 128'(0));
    cycle();
    check("midreset_routing", last[0].data, 128'(A_DEF));
    check("midreset_v", 128'(last[0].v), 128'(4'b1111));
    check("midreset_tok", 128'(last[0].tok), 128'(4'b1111));
    for (int c = 0; c < 8; c++) cycle();
    check("pending_never_applied", last[0].data, 128'(A_DEF));

    in_map[1] = 24'h34; in_en[1] = 8'h7; in_cv[1] = 1'b1;
    cycle();
    in_cv[1] = 1'b0;
    check("u3_range_err", 128'(last[1].err), 128'(1));
    check("u3_range_ready", 128'(last[1].ready), 128'(1));
    in_map[1] = 24'h09; in_cv[1] = 1'b1;
    cycle();
    in_cv[1] = 1'b0;
    in_d[1] = 128'({9'h012, 9'h011, 9'h010}); in_v[1] = 8'h7;
    for (int c = 0; c < 4; c++) cycle();
    check("u3_new_routing", last[1].data, 128'({9'h010, 9'h012, 9'h011}));
    check("u3_new_v", 128'(last[1].v), 128'(3'b111));

    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < 3; k++) begin
        in_d[k] = {$urandom, $urandom, $urandom, $urandom};
        in_v[k] = 8'($urandom); in_tok[k] = 8'($urandom);
        in_cv[k] = ($urandom_range(9, 0) == 0);
        in_en[k] = 8'($urandom);
        if ($urandom_range(1, 0) == 0) begin
          for (int i = 0; i < 8; i++) perm[i] = i;
          for (int i = NCH[k] - 1; i > 0; i--) begin
            int j, t;
            j = int'($urandom_range(i, 0));
            t = perm[i]; perm[i] = perm[j]; perm[j] = t;
          end
          in_map[k] = '0;
          for (int i = 0; i < NCH[k]; i++)
            for (int b = 0; b < LGC[k]; b++) in_map[k][i*LGC[k]+b] = perm[i][b];
        end else begin
          in_map[k] = 24'($urandom);
        end
      end
      pb = last[2].busy;
      cycle();
      if (pb) check("u8_no_valid_while_busy", 128'(last[2].v), 128'(0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
